// File: rtl/uart_frame_parser_pkg.sv
// Shared types and helpers for the UART RX frame parser.
// Holds the parser state encoding, the default protocol bytes, and the
// helpers used for counter widths and saturating statistics.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHK,
        REPLY,
        EMIT
    } state_t;

    localparam int          DEF_MAX_LEN        = 16;
    localparam logic [7:0]  DEF_SYNC_BYTE      = 8'hA5;
    localparam logic [7:0]  DEF_ACK_BYTE       = 8'h06;
    localparam logic [7:0]  DEF_NAK_BYTE       = 8'h15;
    localparam int          DEF_TIMEOUT_CYCLES = 1440000;

    // Bits needed to index n items (0..n-1); never less than one bit.
    function automatic int cnt_width(input int n);
        cnt_width = (n > 1) ? $clog2(n) : 1;
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-level handshakes around the frame parser: RX FIFO pop side,
// TX FIFO write side and the application payload stream.
// The master modport is the parser; slave is its environment.
interface uart_frame_parser_if;

    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_accept;
    logic [7:0] tx_data;
    logic       tx_wren;
    logic       tx_fifo_full;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    modport master (
        input  rx_data, rx_data_ready, tx_fifo_full, out_ready,
        output rx_accept, tx_data, tx_wren, out_data, out_valid, out_last
    );

    modport slave (
        output rx_data, rx_data_ready, tx_fifo_full, out_ready,
        input  rx_accept, tx_data, tx_wren, out_data, out_valid, out_last
    );

endinterface

// File: rtl/uart_frame_parser_buffer.sv
// Payload buffer for the frame parser: MAX_LEN bytes, one synchronous
// write port and one combinational read port addressed by the parser.
module uart_frame_buffer
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int ADDR_W  = cnt_width(DEF_MAX_LEN)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [MAX_LEN];

    // Store one payload byte per accepted pop.
    // NOTE: the array has no reset; it is only read after being written by the current frame.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < MAX_LEN)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (int'(rd_addr) < MAX_LEN) ? mem[rd_addr] : 8'h00;

endmodule

// File: rtl/uart_frame_parser.sv
// UART RX frame parser: pops SYNC, LEN, payload[LEN], CHK from the RX FIFO,
// answers ACK/NAK into the TX FIFO and streams good payloads downstream.
// Optional build macro PARSER_TIMEOUT_EN adds an inter-byte timeout that
// aborts a stalled frame back to HUNT without sending a reply.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN        = DEF_MAX_LEN,
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
    parameter logic [7:0] NAK_BYTE       = DEF_NAK_BYTE,
    parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                sys_clk,
    input  logic                reset,
    uart_frame_parser_if.master bus,
    output logic [15:0]         frame_ok_count,
    output logic [15:0]         frame_err_count
);

    localparam int ADDR_W = cnt_width(MAX_LEN);

    state_t     state;
    logic [7:0] len;
    logic [7:0] chk;
    logic [7:0] idx;
    logic       pop_wait;
    logic       reply_ack;
    logic [7:0] buf_rd_data;

    logic       rx_state;
    logic       pop;
    logic       buf_we;
    logic       len_bad;

    // Bytes are only taken in the four receiving states, and never in the
    // cycle after a pop while the FIFO RAM read catches up.
    assign rx_state = (state == HUNT) || (state == LEN) ||
                      (state == PAYLOAD) || (state == CHK);
    assign pop      = rx_state && bus.rx_data_ready && !pop_wait;
    assign buf_we   = pop && (state == PAYLOAD);
    assign len_bad  = (bus.rx_data == 8'h00) || (bus.rx_data > 8'(MAX_LEN));

    uart_frame_buffer #(
        .MAX_LEN (MAX_LEN),
        .ADDR_W  (ADDR_W)
    ) u_buffer (
        .clk     (sys_clk),
        .wr_en   (buf_we),
        .wr_addr (idx[ADDR_W-1:0]),
        .wr_data (bus.rx_data),
        .rd_addr (idx[ADDR_W-1:0]),
        .rd_data (buf_rd_data)
    );

`ifdef PARSER_TIMEOUT_EN
    localparam int TO_W = cnt_width(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt;
    logic            in_frame;

    assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CHK);
`endif

    // Parser FSM with registered handshake outputs and statistics.
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state           <= HUNT;
            len             <= 8'h00;
            chk             <= 8'h00;
            idx             <= 8'h00;
            pop_wait        <= 1'b0;
            reply_ack       <= 1'b0;
            bus.rx_accept   <= 1'b0;
            bus.tx_data     <= 8'h00;
            bus.tx_wren     <= 1'b0;
            bus.out_data    <= 8'h00;
            bus.out_valid   <= 1'b0;
            bus.out_last    <= 1'b0;
            frame_ok_count  <= 16'h0000;
            frame_err_count <= 16'h0000;
`ifdef PARSER_TIMEOUT_EN
            to_cnt          <= '0;
`endif
        end else begin
            bus.rx_accept <= pop;
            pop_wait      <= pop;
            bus.tx_wren   <= 1'b0;

            case (state)
                HUNT: begin
                    if (pop && (bus.rx_data == SYNC_BYTE)) begin
                        state <= LEN;
                    end
                end

                LEN: begin
                    if (pop) begin
                        len <= bus.rx_data;
                        chk <= bus.rx_data;
                        idx <= 8'h00;
                        if (len_bad) begin
                            reply_ack       <= 1'b0;
                            frame_err_count <= sat_inc(frame_err_count);
                            state           <= REPLY;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end

                PAYLOAD: begin
                    if (pop) begin
                        chk <= chk ^ bus.rx_data;
                        idx <= idx + 8'd1;
                        if ((idx + 8'd1) == len) begin
                            state <= CHK;
                        end
                    end
                end

                CHK: begin
                    if (pop) begin
                        idx   <= 8'h00;
                        state <= REPLY;
                        if (bus.rx_data == chk) begin
                            reply_ack      <= 1'b1;
                            frame_ok_count <= sat_inc(frame_ok_count);
                        end else begin
                            reply_ack       <= 1'b0;
                            frame_err_count <= sat_inc(frame_err_count);
                        end
                    end
                end

                REPLY: begin
                    if (!bus.tx_fifo_full) begin
                        bus.tx_data <= reply_ack ? ACK_BYTE : NAK_BYTE;
                        bus.tx_wren <= 1'b1;
                        if (reply_ack) begin
                            // idx is 0 here, so the buffer read port already shows byte 0.
                            bus.out_data  <= buf_rd_data;
                            bus.out_valid <= 1'b1;
                            bus.out_last  <= (len == 8'd1);
                            idx           <= 8'd1;
                            state         <= EMIT;
                        end else begin
                            state <= HUNT;
                        end
                    end
                end

                EMIT: begin
                    if (bus.out_valid && bus.out_ready) begin
                        if (bus.out_last) begin
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            state         <= HUNT;
                        end else begin
                            bus.out_data <= buf_rd_data;
                            bus.out_last <= ((idx + 8'd1) == len);
                            idx          <= idx + 8'd1;
                        end
                    end
                end

                default: state <= HUNT;
            endcase

`ifdef PARSER_TIMEOUT_EN
            // Inter-byte timeout: placed after the case so an abort overrides it.
            if (!in_frame || pop) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                to_cnt          <= '0;
                state           <= HUNT;
                frame_err_count <= sat_inc(frame_err_count);
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
`endif
        end
    end

endmodule
